// File: rtl/galaksija_sysctl.sv
// Galaksija CPU housekeeping: reset stretcher, fractional cen NCO with turbo, frame interrupt, output latch.
// Latency: all outputs registered, one clk from cause; no backpressure (CPU bus strobes sampled on cen).
module galaksija_sysctl #(
    parameter int unsigned F_CLK       = 25000000,
    parameter int unsigned F_CPU       = 3072000,
    parameter int unsigned F_CPU_TURBO = 6144000,
    parameter int unsigned NCO_BITS    = 20,
    parameter int unsigned F_INT       = 50,
    parameter int unsigned INT_HOLD    = 64,
    parameter int unsigned RST_BITS    = 6,
    parameter int unsigned LATCH_WIDTH = 6,
    parameter logic [15:0] LATCH_ADDR  = 16'h2038,
    parameter logic [15:0] LATCH_MASK  = 16'hFFF8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   turbo,
    output logic                   cpu_resetn,
    output logic                   cen,
    input  logic [15:0]            addr,
    input  logic [7:0]             dout,
    input  logic                   mreq_n,
    input  logic                   wr_n,
    input  logic                   m1_n,
    input  logic                   iorq_n,
    output logic                   int_n,
    output logic [LATCH_WIDTH-1:0] latch_out,
    output logic [7:0]             int_missed
);

    localparam logic [63:0] INC_NORM_64  = (64'(F_CPU) << NCO_BITS) / 64'(F_CLK);
    localparam logic [63:0] INC_TURBO_64 = (64'(F_CPU_TURBO) << NCO_BITS) / 64'(F_CLK);
    localparam logic [NCO_BITS-1:0] INC_NORM  = INC_NORM_64[NCO_BITS-1:0];
    localparam logic [NCO_BITS-1:0] INC_TURBO = INC_TURBO_64[NCO_BITS-1:0];

    localparam int unsigned PERIOD    = F_CLK / F_INT;
    localparam int unsigned PER_BITS  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned HOLD_BITS = $clog2(INT_HOLD + 1);

    localparam logic [PER_BITS-1:0]  PER_LAST  = PER_BITS'(PERIOD - 1);
    localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(INT_HOLD - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Reset stretcher
    logic [RST_BITS:0] rst_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt <= '0;
        end else if (!rst_cnt[RST_BITS]) begin
            rst_cnt <= rst_cnt + 1'b1;
        end
    end

    assign cpu_resetn = rst_cnt[RST_BITS];

    // NCO: a carry arriving while the previous carry is still high is dropped,
    // which keeps cen a single-clk pulse even for rates above F_CLK/2.
    logic [NCO_BITS:0]   acc;
    logic [NCO_BITS-1:0] inc_q;
    logic [NCO_BITS:0]   nco_sum;

    assign nco_sum = {1'b0, acc[NCO_BITS-1:0]} + {1'b0, inc_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            inc_q <= INC_NORM;
        end else begin
            acc <= {nco_sum[NCO_BITS] & ~acc[NCO_BITS], nco_sum[NCO_BITS-1:0]};
            if (acc[NCO_BITS]) begin
                inc_q <= turbo ? INC_TURBO : INC_NORM;
            end
        end
    end

    assign cen = acc[NCO_BITS];

    // Frame interrupt
    logic [PER_BITS-1:0]  per_cnt;
    logic                 tick;
    logic [0:0]           state;
    logic [0:0]           state_nx;
    logic [HOLD_BITS-1:0] hold_cnt;
    logic [HOLD_BITS-1:0] hold_nx;
    logic [7:0]           missed_nx;
    logic                 ack;

    assign tick = (per_cnt == PER_LAST);
    assign ack  = cen & ~m1_n & ~iorq_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt <= '0;
        end else if (tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        hold_nx   = hold_cnt;
        missed_nx = int_missed;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_nx = ST_PEND;
                    hold_nx  = '0;
                end
            end
            default: begin
                if (ack) begin
                    // A fresh tick landing on the acknowledge re-arms cleanly.
                    state_nx = tick ? ST_PEND : ST_IDLE;
                    hold_nx  = '0;
                end else begin
                    if (tick && (int_missed != 8'hFF)) begin
                        missed_nx = int_missed + 8'd1;
                    end
                    if (cen) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_nx = ST_IDLE;
                        end else begin
                            hold_nx = hold_cnt + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            int_missed <= '0;
        end else begin
            state      <= state_nx;
            hold_cnt   <= hold_nx;
            int_missed <= missed_nx;
        end
    end

    assign int_n = (state == ST_IDLE);

    // Output latch
    logic latch_wr;
    logic unused_dout;

    assign latch_wr    = cen & cpu_resetn & ~mreq_n & ~wr_n & ((addr & LATCH_MASK) == LATCH_ADDR);
    assign unused_dout = ^dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch_out <= '0;
        end else if (latch_wr) begin
            latch_out <= dout[7 -: LATCH_WIDTH];
        end
    end

endmodule

// File: doc/galaksija_sysctl.md
Name: galaksija_sysctl

Overview:
Parametrised system-control block for the Galaksija core. It gathers the CPU-side housekeeping logic into one unit: reset stretcher, fractional CPU clock-enable with a glitch-free turbo mode, and a periodic frame interrupt with acknowledge, timeout and overrun counting. It also provides a memory-mapped output latch of configurable width and decode. It sits between the tv80n CPU and the top-level pins (EEPROM/serial latch bits, interrupt, cen).

Parameters:
F_CLK, 25000000, core clock frequency in Hz
F_CPU, 3072000, normal CPU clock-enable rate in Hz
F_CPU_TURBO, 6144000, turbo CPU clock-enable rate in Hz
NCO_BITS, 20, fractional accumulator width, excluding the carry bit
F_INT, 50, frame interrupt rate in Hz
INT_HOLD, 64, maximum number of cen pulses int_n stays low without an acknowledge
RST_BITS, 6, reset stretch of 2^RST_BITS clk cycles
LATCH_WIDTH, 6, latch width; takes dout[7 -: LATCH_WIDTH]
LATCH_ADDR, 16'h2038, latch decode base address
LATCH_MASK, 16'hFFF8, latch decode mask

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
turbo  input  1  selects F_CPU_TURBO when 1
cpu_resetn  output  1  stretched CPU reset, active low
cen  output  1  one-clk CPU clock-enable pulse
addr  input  16  CPU address bus
dout  input  8  CPU data out
mreq_n  input  1  CPU memory request
wr_n  input  1  CPU write strobe
m1_n  input  1  CPU M1
iorq_n  input  1  CPU IORQ
int_n  output  1  maskable interrupt request to the CPU
latch_out  output  LATCH_WIDTH  latched control bits
int_missed  output  8  saturating count of overrun interrupts

Behaviour:
- All state clears asynchronously on reset_n=0. Values during reset: cpu_resetn=0, cen=0, int_n=1, latch_out=0, int_missed=0.
- Reset stretcher: a counter of RST_BITS+1 bits. It increments every clk while its MSB is 0 and freezes once the MSB is 1. cpu_resetn is the MSB, so it rises 2^RST_BITS clks after reset_n is released.
- NCO:
  - Accumulator is NCO_BITS+1 bits. The increment is floor(F*2^NCO_BITS/F_CLK), computed with 64-bit arithmetic, where F is F_CPU or F_CPU_TURBO.
  - Each clk, the low NCO_BITS bits are replaced by the low bits of the sum. The carry bit is set only if the sum carried and the previous carry bit was 0.
  - cen equals the carry bit, so it is never high on two consecutive clks.
  - The active increment is reloaded from turbo only on a clk where cen=1. A change of turbo therefore takes effect after the next cen pulse.
  - The NCO runs regardless of cpu_resetn.
- Interrupt timer:
  - Period counter counts 0..F_CLK/F_INT-1 and wraps. On wrap a tick is generated.
  - States: IDLE (int_n=1) and PEND (int_n=0).
  - IDLE→PEND on a tick; the hold counter loads 0.
  - PEND→IDLE on acknowledge: m1_n=0 and iorq_n=0 on a clk with cen=1.
  - PEND→IDLE on timeout: the hold counter, which increments on each cen, reaches INT_HOLD.
  - Tick while in PEND: stay in PEND, do not reset the hold counter, and increment int_missed, saturating at 255.
  - Tick and acknowledge on the same clk: acknowledge wins, next state is PEND with the hold counter at 0, and int_missed is unchanged.
  - int_n is registered.
- Latch:
  - A write occurs on a clk with cen=1, mreq_n=0, wr_n=0 and (addr & LATCH_MASK)==LATCH_ADDR.
  - On a write, latch_out <= dout[7 -: LATCH_WIDTH]. Repeated writes during one bus cycle are idempotent.
  - Writes are blocked while cpu_resetn=0.
- Reset mid-operation: reset_n low at any time returns every output to its reset value immediately. The stretch sequence then restarts from 0.

Test Plan:
- Release reset_n at t0 → cpu_resetn=0 for exactly 64 clks, then 1. cen never high for 2 consecutive clks.
- turbo=0, count cen over 250000 clks → 30720±1. Set turbo=1 → no change before the next cen, then 61440±1 per 250000 clks.
- No acknowledge → int_n falls at clk 500000 after release and returns to 1 after 64 cen pulses. int_missed=0.
- Assert m1_n=iorq_n=0 on the 3rd cen after int_n falls → int_n=1 on the next clk. Hold acknowledge off with INT_HOLD=2^20 → a second tick increments int_missed to 1 and int_n stays 0.
- Write dout=8'hA4 at 16'h203C with cen=1 → latch_out=6'h29. Write at 16'h2040 → latch_out unchanged. Write during cpu_resetn=0 → ignored.
- Pulse reset_n low for 1 clk while int_n=0 and latch_out=6'h29 → int_n=1, latch_out=0, int_missed=0, cpu_resetn=0, and the 64-clk stretch repeats.
